// File: rtl/ccd_queue.sv
// Clock-domain-crossing request queue: buffers fast-side memory requests and
// replays them one at a time on a slow side driven by a clock enable.
module ccd_queue #(
    parameter int clock_rate = 4,
    parameter int fifo_depth = 4
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        memory_valid,
    input  logic        memory_instr,
    input  logic [31:0] memory_addr,
    input  logic [31:0] memory_wdata,
    input  logic [3:0]  memory_wstrb,
    output logic [31:0] memory_rdata,
    output logic        memory_ready,
    output logic        memory_full,
    output logic        memory_overflow,
    output logic        memory_slow_tick,
    output logic        memory_slow_valid,
    output logic        memory_slow_instr,
    output logic [31:0] memory_slow_addr,
    output logic [31:0] memory_slow_wdata,
    output logic [3:0]  memory_slow_wstrb,
    input  logic [31:0] memory_slow_rdata,
    input  logic        memory_slow_ready
);

    // state | meaning
    // IDLE  | no slow transaction outstanding
    // ISSUE | issue register presented on the slow port until the next tick
    // WAIT  | request taken, waiting for slow_ready on a tick

    localparam int CW = (clock_rate > 1) ? $clog2(clock_rate) : 1;
    localparam int PW = $clog2(fifo_depth);
    localparam int EW = 69;
    localparam logic [CW-1:0] CNT_LAST = CW'(clock_rate - 1);
    localparam logic [PW:0]   DEPTH    = (PW + 1)'(fifo_depth);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2
    } state_t;

    state_t          state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [PW:0]     count_q, count_d;
    logic [EW-1:0]   fifo_q [fifo_depth];
    logic [EW-1:0]   iss_q, iss_d;
    logic            ovf_q, ovf_d;
    logic            rdy_q, rdy_d;
    logic [31:0]     rdata_q, rdata_d;

    logic            tick;
    logic            full;
    logic            empty;
    logic            push;
    logic            pop;
    logic            done;
    logic [EW-1:0]   push_entry;

    assign tick       = (cnt_q == CNT_LAST);
    assign full       = (count_q == DEPTH);
    assign empty      = (count_q == '0);
    assign push       = memory_valid && !full;
    assign push_entry = {memory_instr, memory_addr, memory_wdata, memory_wstrb};

    always_comb begin
        state_d = state_q;
        pop     = 1'b0;
        done    = 1'b0;
        case (state_q)
            IDLE: begin
                if (tick && !empty) begin
                    pop     = 1'b1;
                    state_d = ISSUE;
                end
            end
            ISSUE, WAIT: begin
                if (tick) begin
                    if (memory_slow_ready) begin
                        done = 1'b1;
                        if (!empty) begin
                            pop     = 1'b1;
                            state_d = ISSUE;
                        end else begin
                            state_d = IDLE;
                        end
                    end else begin
                        state_d = WAIT;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        cnt_d    = tick ? '0 : cnt_q + CW'(1);
        wr_ptr_d = push ? wr_ptr_q + PW'(1) : wr_ptr_q;
        rd_ptr_d = pop ? rd_ptr_q + PW'(1) : rd_ptr_q;
        case ({push, pop})
            2'b10:   count_d = count_q + (PW + 1)'(1);
            2'b01:   count_d = count_q - (PW + 1)'(1);
            default: count_d = count_q;
        endcase
        iss_d   = pop ? fifo_q[rd_ptr_q] : iss_q;
        // A pop this cycle never frees room for a request arriving this cycle.
        ovf_d   = ovf_q | (memory_valid & full);
        rdy_d   = done;
        rdata_d = done ? memory_slow_rdata : 32'd0;
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            iss_q    <= '0;
            ovf_q    <= 1'b0;
            rdy_q    <= 1'b0;
            rdata_q  <= 32'd0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            iss_q    <= iss_d;
            ovf_q    <= ovf_d;
            rdy_q    <= rdy_d;
            rdata_q  <= rdata_d;
        end
    end

    // Storage needs no reset: an entry is never read before it is written.
    always_ff @(posedge clock) begin
        if (push) begin
            fifo_q[wr_ptr_q] <= push_entry;
        end
    end

    always_comb begin
        memory_slow_tick  = tick;
        memory_slow_valid = 1'b0;
        memory_slow_instr = 1'b0;
        memory_slow_addr  = 32'd0;
        memory_slow_wdata = 32'd0;
        memory_slow_wstrb = 4'd0;
        if (state_q == ISSUE) begin
            memory_slow_valid = 1'b1;
            memory_slow_instr = iss_q[68];
            memory_slow_addr  = iss_q[67:36];
            memory_slow_wdata = iss_q[35:4];
            memory_slow_wstrb = iss_q[3:0];
        end
    end

    assign memory_ready    = rdy_q;
    assign memory_rdata    = rdata_q;
    assign memory_full     = full;
    assign memory_overflow = ovf_q;

endmodule

// File: doc/ccd_queue.md
CCD_QUEUE -- requirements
Module: ccd_queue

Interface
REQ-001 The block SHALL have parameter clock_rate, default 4, meaning fast cycles per slow tick (legal range 1 to 256).
REQ-002 The block SHALL have parameter fifo_depth, default 4, meaning request FIFO entries (power of 2, at least 2).
REQ-003 Port clock, in, 1: the single clock; all state SHALL update on its rising edge.
REQ-004 Port reset, in, 1: synchronous, active-low reset.
REQ-005 Port memory_valid, in, 1: one-cycle request pulse from the fast side.
REQ-006 Ports memory_instr (1), memory_addr (32), memory_wdata (32), memory_wstrb (4), in: request fields, sampled when memory_valid=1.
REQ-007 Ports memory_rdata (32), memory_ready (1), out: completion data and one-cycle completion pulse.
REQ-008 Ports memory_full (1), memory_overflow (1), out: FIFO full; sticky dropped-request flag.
REQ-009 Port memory_slow_tick, out, 1: slow-side clock enable.
REQ-010 Ports memory_slow_valid (1), memory_slow_instr (1), memory_slow_addr (32), memory_slow_wdata (32), memory_slow_wstrb (4), out: slow request.
REQ-011 Ports memory_slow_rdata (32), memory_slow_ready (1), in: slow response, meaningful only on tick cycles.

Function
REQ-012 Tick counter SHALL count 0 to clock_rate-1 and wrap to 0.
- memory_slow_tick = 1 combinationally when count = clock_rate-1.
- clock_rate=1: tick is high every cycle.
REQ-013 Push SHALL occur when memory_valid=1 and the registered FIFO count < fifo_depth.
- Stored entry: {instr, addr, wdata, wstrb}.
- Push is visible to pop logic the next cycle.
REQ-014 If memory_valid=1 while full (registered count = fifo_depth), the request SHALL be dropped and memory_overflow set.
- memory_overflow is cleared only by reset.
- A pop in the same cycle does not make room for that request.
REQ-015 memory_full SHALL equal (registered count = fifo_depth).
REQ-016 Push and pop in the same cycle SHALL leave count unchanged; pointers wrap modulo fifo_depth.
REQ-017 The FSM SHALL have states IDLE, ISSUE and WAIT.
REQ-018 IDLE -> ISSUE on a tick cycle with FIFO non-empty.
- The head entry is popped into the issue register.
REQ-019 In ISSUE, memory_slow_valid SHALL be 1 and memory_slow_* SHALL equal the issue register.
- This holds from the cycle after the pop through the next tick cycle inclusive.
- Outside ISSUE, all memory_slow_* outputs are 0.
REQ-020 In ISSUE at a tick: memory_slow_ready=1 completes the transaction; otherwise the FSM goes to WAIT.
REQ-021 In WAIT at a tick: memory_slow_ready=1 completes the transaction; otherwise the FSM stays in WAIT (no timeout).
REQ-022 Completion SHALL register memory_slow_rdata.
- memory_ready=1 and memory_rdata = that value for exactly one cycle, the cycle after the completing tick.
- Applies to reads and writes alike.
- memory_rdata is 0 whenever memory_ready=0.
REQ-023 On completion with FIFO non-empty, the FSM SHALL pop the next entry in that same tick and go to ISSUE; otherwise it goes to IDLE.
REQ-024 Requests SHALL complete in FIFO order, one outstanding slow transaction at a time.

Reset
REQ-025 With reset=0 at a rising edge, the block SHALL reset:
- count to 0, FSM to IDLE;
- FIFO empty, pointers 0;
- memory_overflow 0, issue register 0.
REQ-026 From the cycle after reset, the block SHALL hold:
- memory_ready, memory_rdata, memory_full, memory_slow_valid, all memory_slow_* outputs = 0;
- memory_slow_tick = 1 only if clock_rate=1.
REQ-027 Reset mid-transaction SHALL abandon the in-flight and queued requests; no memory_ready is produced for them.

Verification
REQ-028 clock_rate=4; read addr 0x100 at cycle 0 after reset; slow_ready=1, rdata=0xDEADBEEF at cycle 7 -> slow_valid cycles 4-7, memory_ready with rdata 0xDEADBEEF at cycle 8 only.
REQ-029 clock_rate=4, fifo_depth=4; slow_ready held 0; five requests on cycles 0-4 -> memory_full=1 from cycle 5 (4 queued, 1 in ISSUE), no overflow.
- Then a sixth request -> dropped, memory_overflow=1.
REQ-030 Three queued writes (wstrb 0xF, 0x3, 0x1); slow_ready=1 at first tick each time -> three completions, 4 cycles apart, slow requests in push order.
REQ-031 clock_rate=1; request each cycle for 3 cycles, slow_ready=1 always -> memory_ready on 3 consecutive cycles, starting 3 cycles after the first request.
REQ-032 Reset asserted in WAIT with 2 queued requests, then slow_ready=1 -> no memory_ready; all outputs 0; FIFO empty.
REQ-033 Push into a full FIFO on the same cycle as a completion pop -> request dropped, memory_overflow=1, count = fifo_depth-1.
